seq_tx: RTL and testbench
=========================

SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 Parameter WIDTH, default 8: maximum pattern length in bits.
REQ-002 Parameter GAP, default 1: idle cycles inserted between repetitions; 0 means no gap.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  request to transmit; sampled only in IDLE.
REQ-006 pattern  input  WIDTH  bits to send, MSB-first, starting at bit len-1.
REQ-007 len  input  $clog2(WIDTH)+1  number of bits per burst.
REQ-008 reps  input  4  extra repetitions; 0 = send once, 15 = send 16 times.
REQ-009 out  output  1  registered serial bit stream; the stimulus source for the sequence detector.
REQ-010 valid  output  1  high in every cycle that out carries a pattern bit.
REQ-011 busy  output  1  high from capture until the cycle DONE is exited.
REQ-012 done  output  1  one-cycle pulse after the final bit of the final repetition.

Function
REQ-013 The FSM SHALL have four states: IDLE, SEND, GAP, DONE.
REQ-014 In IDLE, out, valid and done SHALL be 0, and busy SHALL be 0.
REQ-015 At an edge in IDLE with start=1, the block SHALL capture pattern, len and reps, enter SEND, and drive out=pattern[len-1] and valid=1 from that same edge.
REQ-016 In SEND, each following edge SHALL advance one bit toward bit 0; exactly len bits SHALL be emitted per burst, with no bubbles.
REQ-017 len=0 and len>WIDTH SHALL both be treated as WIDTH.
REQ-018 After the last bit with remaining reps >0, the counter SHALL decrement and the FSM SHALL enter GAP for GAP cycles (out=0, valid=0), then restart SEND from bit len-1.
REQ-019 When GAP=0, the next burst SHALL follow the previous one back-to-back.
REQ-020 After the last bit with remaining reps =0, the FSM SHALL enter DONE for exactly one cycle (done=1, out=0, valid=0, busy=1), then return to IDLE.
REQ-021 start SHALL be ignored in SEND, GAP and DONE; pattern, len and reps SHALL be ignored after capture.
REQ-022 start held high continuously SHALL cause a new capture in the first IDLE cycle after DONE, i.e. one idle cycle between transactions.
REQ-023 Total busy duration SHALL be (reps+1)*len + reps*GAP + 1 cycles.

Reset
REQ-024 While reset=1, the block SHALL be in IDLE with out=0, valid=0, busy=0, done=0, and all counters and the shift register at 0.
REQ-025 Reset asserted mid-burst SHALL abort the transfer immediately, and no partial done pulse SHALL be emitted.
REQ-026 After reset deasserts, the first capture SHALL occur at the first rising edge with start=1.

Structure
REQ-027 Package seq_tx_pkg SHALL hold the state enum (IDLE, SEND, GAP, DONE) and the default WIDTH and GAP constants.
REQ-028 Sub-module seq_tx_shift (loadable MSB-first shift register with bit counter and last flag) SHALL be instantiated once; the FSM and rep/gap counters SHALL remain in seq_tx.
REQ-029 out SHALL come directly from a flop, with no combinational path from inputs.

Verification
REQ-030 Basic burst: pattern=8'b0000_1001, len=4, reps=0, start for 1 cycle -> out=1,0,0,1 with valid=1 for 4 cycles, then done=1 for 1 cycle, then busy=0.
REQ-031 Repeats with gap: pattern=3'b101, len=3, reps=2, GAP=1 -> out=1,0,1,0,1,0,1,0,1,0,1; valid low on the 2 gap cycles; busy high for 12 cycles.
REQ-032 Clamp: len=0, pattern=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1 are emitted.
REQ-033 Ignored start: start pulses while busy, and pattern changed mid-burst -> the stream is unchanged and no extra transaction occurs.
REQ-034 Abort: reset pulsed on the 3rd bit of an 8-bit burst -> out=0, busy=0 immediately, no done; a new start afterwards sends the full pattern.
REQ-035 Loopback: seq_tx out drives the sequence-detector in with pattern 0100_0101 -> the detector out matches its expected cycle-by-cycle response.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the seq_tx serial pattern transmitter.
package seq_tx_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefGap   = 1;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap,
    StDone
  } state_e;

endpackage

// File: rtl/seq_tx_if.sv
// Request/stream bundle between a pattern source (master) and seq_tx (slave).
interface seq_tx_if
  import seq_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
);
  localparam int unsigned LenW = $clog2(WIDTH) + 1;

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LenW-1:0]  len;
  logic [3:0]       reps;
  logic             out;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, reps,
    input  out, valid, busy, done
  );

  modport slave (
    input  start, pattern, len, reps,
    output out, valid, busy, done
  );

endinterface

// File: rtl/seq_tx_shift.sv
// MSB-first shift register that keeps a copy of the captured pattern so a burst
// can be replayed; bit_o is the register MSB, last_o flags the final bit.
module seq_tx_shift
  import seq_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LenW  = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             restart_i,
  input  logic             shift_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [LenW-1:0]  len_i,
  output logic             bit_o,
  output logic             last_o
);

  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [LenW-1:0]  len_q, len_d;
  logic [LenW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] aligned;

  // Left-align so bit len-1 of the pattern sits at the MSB.
  assign aligned = pattern_i << (LenW'(WIDTH) - len_i);

  always_comb begin
    pat_d  = pat_q;
    sreg_d = sreg_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      pat_d  = aligned;
      sreg_d = aligned;
      len_d  = len_i;
      cnt_d  = len_i;
    end else if (restart_i) begin
      sreg_d = pat_q;
      cnt_d  = len_q;
    end else if (shift_i) begin
      sreg_d = sreg_q << 1;
      cnt_d  = cnt_q - LenW'(1);
    end else if (clear_i) begin
      sreg_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat_q  <= '0;
      sreg_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      sreg_q <= sreg_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bit_o  = sreg_q[WIDTH-1];
  assign last_o = (cnt_q == LenW'(1));

endmodule

// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first reps+1 times,
// separated by GAP idle cycles, then pulses done for one cycle.
module seq_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned GAP   = DefGap
) (
  input logic   clock,
  input logic   reset,
  seq_tx_if.slave bus
);

  localparam int unsigned LenW = $clog2(WIDTH) + 1;
  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP > 0) ? GAP - 1 : 0);

  state_e          state_q, state_d;
  logic [3:0]      rep_q, rep_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            load, restart, shift, clear;
  logic            last, out_bit;
  logic [LenW-1:0] len_eff;

  // Zero and oversize lengths both mean a full-width burst.
  always_comb begin
    len_eff = bus.len;
    if (bus.len == '0 || bus.len > LenW'(WIDTH)) begin
      len_eff = LenW'(WIDTH);
    end
  end

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    load    = 1'b0;
    restart = 1'b0;
    shift   = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          load    = 1'b1;
          rep_d   = bus.reps;
          state_d = StSend;
        end
      end
      StSend: begin
        if (!last) begin
          shift = 1'b1;
        end else if (rep_q != 4'd0) begin
          rep_d = rep_q - 4'd1;
          if (GAP == 0) begin
            restart = 1'b1;
          end else begin
            clear   = 1'b1;
            gap_d   = GapLast;
            state_d = StGap;
          end
        end else begin
          clear   = 1'b1;
          state_d = StDone;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          restart = 1'b1;
          state_d = StSend;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d = (state_d == StSend);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rep_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  seq_tx_shift #(
    .WIDTH (WIDTH),
    .LenW  (LenW)
  ) u_shift (
    .clock     (clock),
    .reset     (reset),
    .load_i    (load),
    .restart_i (restart),
    .shift_i   (shift),
    .clear_i   (clear),
    .pattern_i (bus.pattern),
    .len_i     (len_eff),
    .bit_o     (out_bit),
    .last_o    (last)
  );

  assign bus.out   = out_bit;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// Drives GAP=1 and GAP=0 instances with identical requests and compares each
// cycle's {out,valid,busy,done} against a burst-level reference model.
module tb_seq_tx;

  typedef logic [3:0] vec_q_t[$];

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  seq_tx_if #(.WIDTH(8)) bus_g1 ();
  seq_tx_if #(.WIDTH(8)) bus_g0 ();

  assign bus_g0.start   = bus_g1.start;
  assign bus_g0.pattern = bus_g1.pattern;
  assign bus_g0.len     = bus_g1.len;
  assign bus_g0.reps    = bus_g1.reps;

  seq_tx #(.WIDTH(8), .GAP(1)) u_g1 (.clock(clock), .reset(reset), .bus(bus_g1));
  seq_tx #(.WIDTH(8), .GAP(0)) u_g0 (.clock(clock), .reset(reset), .bus(bus_g0));

  always #5 clock = ~clock;

  function automatic logic [3:0] obs_g1();
    return {bus_g1.out, bus_g1.valid, bus_g1.busy, bus_g1.done};
  endfunction

  function automatic logic [3:0] obs_g0();
    return {bus_g0.out, bus_g0.valid, bus_g0.busy, bus_g0.done};
  endfunction

  function automatic int eff_len(input int len);
    return (len == 0 || len > 8) ? 8 : len;
  endfunction

  // Expected per-cycle {out,valid,busy,done} from capture edge through DONE.
  function automatic vec_q_t model(input logic [7:0] pat, input int len, input int reps,
                                   input int gap);
    vec_q_t q;
    int     l = eff_len(len);
    for (int r = 0; r <= reps; r++) begin
      for (int i = l - 1; i >= 0; i--) q.push_back({pat[i], 3'b110});
      if (r < reps) for (int g = 0; g < gap; g++) q.push_back(4'b0010);
    end
    q.push_back(4'b0011);
    return q;
  endfunction

  task automatic check(input string tag, input int cyc, input logic [3:0] obs,
                       input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d {out,valid,busy,done} got=%b want=%b", tag, cyc, obs, exp);
    end
  endtask

  // Must be entered right after a negedge; returns right after a negedge.
  task automatic run(input logic [7:0] pat, input int len, input int reps, input bit noisy,
                     input bit hold, input string tag);
    vec_q_t e1, e0, t;
    int     n, lim, l;
    l  = eff_len(len);
    e1 = model(pat, len, reps, 1);
    e0 = model(pat, len, reps, 0);
    if (hold) begin
      t = model(pat, len, reps, 1);
      e1.push_back(4'b0000);
      e0.push_back(4'b0000);
      foreach (t[i]) begin
        e1.push_back(t[i]);
        e0.push_back(t[i]);
      end
    end
    n   = ((e1.size() > e0.size()) ? e1.size() : e0.size()) + 2;
    lim = (e1.size() < e0.size()) ? e1.size() : e0.size();
    bus_g1.start   = 1'b1;
    bus_g1.pattern = pat;
    bus_g1.len     = 4'(len);
    bus_g1.reps    = 4'(reps);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check({tag, "/gap1"}, k, obs_g1(), (k < e1.size()) ? e1[k] : 4'b0000);
      check({tag, "/gap0"}, k, obs_g0(), (k < e0.size()) ? e0[k] : 4'b0000);
      if (hold) bus_g1.start = (k <= l + 1);
      else if (noisy && k < lim) bus_g1.start = 1'($urandom_range(0, 1));
      else bus_g1.start = 1'b0;
      if (noisy) begin
        bus_g1.pattern = 8'($urandom);
        bus_g1.len     = 4'($urandom);
        bus_g1.reps    = 4'($urandom);
      end
    end
    bus_g1.start = 1'b0;
  endtask

  initial begin
    bus_g1.start   = 1'b0;
    bus_g1.pattern = '0;
    bus_g1.len     = '0;
    bus_g1.reps    = '0;
    #1 reset = 1'b1;
    bus_g1.start = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("reset/gap1", 0, obs_g1(), 4'b0000);
      check("reset/gap0", 0, obs_g0(), 4'b0000);
    end
    bus_g1.start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("idle/gap1", 0, obs_g1(), 4'b0000);

    run(8'b0000_1001, 4, 0, 1'b0, 1'b0, "basic");
    run(8'b0000_0101, 3, 2, 1'b0, 1'b0, "gap");
    run(8'hA5, 0, 0, 1'b0, 1'b0, "clamp0");
    run(8'h3C, 12, 1, 1'b0, 1'b0, "clamp12");
    run(8'hB2, 6, 2, 1'b1, 1'b0, "ignored");
    run(8'h5A, 5, 0, 1'b0, 1'b1, "held");
    run(8'h45, 8, 0, 1'b0, 1'b0, "loop");
    run(8'h96, 1, 15, 1'b0, 1'b0, "len1x16");

    // Abort during the third bit of an 8-bit burst.
    bus_g1.start   = 1'b1;
    bus_g1.pattern = 8'hC7;
    bus_g1.len     = 4'd8;
    bus_g1.reps    = 4'd1;
    @(negedge clock);
    bus_g1.start = 1'b0;
    check("abort_b7/gap1", 0, obs_g1(), 4'b1110);
    @(negedge clock);
    check("abort_b6/gap1", 1, obs_g1(), 4'b1110);
    @(negedge clock);
    check("abort_b5/gap1", 2, obs_g1(), 4'b0110);
    reset = 1'b1;
    #1;
    check("abort_now/gap1", 2, obs_g1(), 4'b0000);
    check("abort_now/gap0", 2, obs_g0(), 4'b0000);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      check("abort_quiet/gap1", k, obs_g1(), 4'b0000);
      check("abort_quiet/gap0", k, obs_g0(), 4'b0000);
    end
    run(8'hC7, 8, 0, 1'b0, 1'b0, "after_abort");

    for (int i = 0; i < 20; i++) begin
      run(8'($urandom), $urandom_range(0, 15), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), 1'b0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
